// File: rtl/note_sequencer_if.sv
// Request channel of the note sequencer: {divider, beats} entries over valid/ready.
interface note_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] in_div;
  logic [7:0]  in_beats;

  modport master (output in_valid, output in_div, output in_beats, input in_ready);
  modport slave  (input in_valid, input in_div, input in_beats, output in_ready);
endinterface

// File: rtl/note_sequencer.sv
// Note queue and beat timer feeding the square-wave generator's divider.
// Define NOTE_SEQ_GAP_EN to insert GAP_CYCLES of silence after every note.
module note_sequencer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned BEAT_DIV   = 12500000,
  parameter int unsigned GAP_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   play,
  input  logic                   clear,
  note_sequencer_if.slave        req,
  output logic [21:0]            note_div,
  output logic                   mute,
  output logic                   note_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(BEAT_DIV);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_DIV - 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("note_sequencer: DEPTH must be a power of two >= 2");
  end
  if (BEAT_DIV < 2 || GAP_CYCLES < 1) begin : g_bad_timing
    $error("note_sequencer: BEAT_DIV must be >= 2 and GAP_CYCLES >= 1");
  end

`ifdef NOTE_SEQ_GAP_EN
  localparam int unsigned GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
  logic [GW-1:0] gap_cnt;
`else
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
`endif

  state_t        state;
  logic [29:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [BW-1:0] beat_cnt;
  logic [7:0]    beats_left;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          note_end;
  logic [21:0]   head_div;
  logic [7:0]    head_beats;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign req.in_ready = !full;
  assign push        = req.in_valid && !full;
  assign pop         = (state == LOAD);
  assign {head_div, head_beats} = mem[rd_ptr];

  // Last unpaused cycle of the note; suppressed when the cycle is flushed.
  assign note_end  = (state == PLAY) && play && (beat_cnt == BEAT_LAST) && (beats_left == 8'd1);
  assign note_done = note_end && !clear && !rst;
  assign mute      = !((state == PLAY) && play && (note_div != '0));
  assign busy      = (state != IDLE);
  assign level     = count;

  always_ff @(posedge clk) begin
    if (!rst && !clear && push) mem[wr_ptr] <= {req.in_div, req.in_beats};
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      beat_cnt   <= '0;
      beats_left <= '0;
      note_div   <= '0;
`ifdef NOTE_SEQ_GAP_EN
      gap_cnt    <= '0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);

      case (state)
        IDLE: if (play && !empty) state <= LOAD;
        LOAD: begin
          note_div   <= head_div;
          beats_left <= (head_beats == '0) ? 8'd1 : head_beats;
          beat_cnt   <= '0;
          state      <= PLAY;
        end
        PLAY: if (play) begin
          if (beat_cnt == BEAT_LAST) begin
            beat_cnt   <= '0;
            beats_left <= beats_left - 8'd1;
            if (beats_left == 8'd1) begin
`ifdef NOTE_SEQ_GAP_EN
              gap_cnt <= '0;
              state   <= GAP;
`else
              if (!empty) state <= LOAD;
              else begin
                state    <= IDLE;
                note_div <= '0;
              end
`endif
            end
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
`ifdef NOTE_SEQ_GAP_EN
        GAP: if (play) begin
          if (gap_cnt == GAP_LAST) begin
            if (!empty) state <= LOAD;
            else begin
              state    <= IDLE;
              note_div <= '0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
